// File: rtl/acc_48bits.sv
// Frame-based 48-bit signed accumulator with valid/ready on both sides.
// The running sum is fed back through a combinational carry-lookahead adder.

module cla_48bits (
  input  logic [47:0] a,
  input  logic [47:0] b,
  input  logic        cin,
  output logic [47:0] s
);
  logic [47:0] p, g, c;
  logic [11:0] grp_g, grp_p;
  logic [12:0] grp_c;

  // Four-bit lookahead groups, with group generate/propagate chained across groups.
  always_comb begin
    p = a ^ b;
    g = a & b;
    grp_g = '0;
    grp_p = '0;
    grp_c = '0;
    c = '0;
    grp_c[0] = cin;
    for (int k = 0; k < 12; k++) begin
      grp_g[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      grp_p[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
      grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
      c[4*k]   = grp_c[k];
      c[4*k+1] = g[4*k] | (p[4*k] & grp_c[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & grp_c[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & grp_c[k]);
    end
    s = p ^ c;
  end
endmodule

module acc_48bits #(
  parameter logic SAT   = 1'b1,
  parameter int   CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [47:0]      in_data,
  input  logic             in_sub,
  input  logic             in_clr,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [47:0]      out_data,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_cnt
);
  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic [47:0] MAX_POS = 48'h7FFF_FFFF_FFFF;
  localparam logic [47:0] MAX_NEG = 48'h8000_0000_0000;

  state_t             state_q, state_d;
  logic [47:0]        acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;
  logic [47:0]        out_data_q, out_data_d;
  logic               out_ovf_q, out_ovf_d;
  logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;

  logic [47:0]        base, b_op, sum, acc_upd;
  logic [CNT_W-1:0]   cnt_base, cnt_upd;
  logic               ovf, ovf_upd, accept;

  cla_48bits u_cla (
    .a   (base),
    .b   (b_op),
    .cin (in_sub),
    .s   (sum)
  );

  assign in_ready  = ~out_valid_q | out_ready;
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign out_cnt   = out_cnt_q;

  // Updated frame values including the current beat; committed only on accept.
  always_comb begin
    base     = in_clr ? '0 : acc_q;
    b_op     = in_sub ? ~in_data : in_data;
    ovf      = (base[47] == b_op[47]) & (sum[47] != base[47]);
    acc_upd  = sum;
    if (ovf && SAT) acc_upd = base[47] ? MAX_NEG : MAX_POS;
    ovf_upd  = (~in_clr & ovf_q) | ovf;
    cnt_base = in_clr ? '0 : cnt_q;
    cnt_upd  = (&cnt_base) ? cnt_base : cnt_base + CNT_W'(1);
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q & ~out_ready;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    out_cnt_d   = out_cnt_q;
    if (accept) begin
      if (in_last) begin
        state_d     = IDLE;
        acc_d       = '0;
        cnt_d       = '0;
        ovf_d       = 1'b0;
        out_valid_d = 1'b1;
        out_data_d  = acc_upd;
        out_ovf_d   = ovf_upd;
        out_cnt_d   = cnt_upd;
      end else begin
        state_d = ACCUM;
        acc_d   = acc_upd;
        cnt_d   = cnt_upd;
        ovf_d   = ovf_upd;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      out_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      out_cnt_q   <= out_cnt_d;
    end
  end
endmodule

// File: tb/tb_acc_48bits.sv
// Directed bench for acc_48bits: a saturating 16-bit-count instance and a
// wrapping 2-bit-count instance share the same stimulus.

module tb_acc_48bits;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_sub, in_clr, in_last, out_ready;
  logic [47:0] in_data;

  logic        s_in_ready, s_out_valid, s_out_ovf;
  logic [47:0] s_out_data;
  logic [15:0] s_out_cnt;
  logic        w_in_ready, w_out_valid, w_out_ovf;
  logic [47:0] w_out_data;
  logic [1:0]  w_out_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  acc_48bits #(.SAT(1'b1), .CNT_W(16)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_sub(in_sub), .in_clr(in_clr), .in_last(in_last),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .out_ovf(s_out_ovf), .out_cnt(s_out_cnt)
  );

  acc_48bits #(.SAT(1'b0), .CNT_W(2)) dut_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_data(in_data), .in_sub(in_sub), .in_clr(in_clr), .in_last(in_last),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_data(w_out_data),
    .out_ovf(w_out_ovf), .out_cnt(w_out_cnt)
  );

  // Present one beat, let one rising edge pass, and return 1 time unit later.
  task automatic send(input logic [47:0] d, input logic sub, input logic clr, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_sub   = sub;
    in_clr   = clr;
    in_last  = last;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_clr   = 1'b0;
    in_last  = 1'b0;
    in_sub   = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    total++; if (s_out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_valid got=%b exp=0", s_out_valid); end
    total++; if (s_out_data !== 48'd0) begin bad++; $display("[TB] FAIL rst_data got=%h exp=0", s_out_data); end
    total++; if (s_out_cnt !== 16'd0 || s_out_ovf !== 1'b0) begin bad++; $display("[TB] FAIL rst_cnt_ovf got=%0d/%b exp=0/0", s_out_cnt, s_out_ovf); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (s_in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_in_ready got=%b exp=1", s_in_ready); end
  endtask

  task automatic test_basic();
    send(48'd5, 1'b0, 1'b0, 1'b0);
    total++; if (s_out_valid !== 1'b0) begin bad++; $display("[TB] FAIL basic_early_valid got=%b exp=0", s_out_valid); end
    send(48'd7, 1'b0, 1'b0, 1'b0);
    send(48'hFFFF_FFFF_FFFD, 1'b0, 1'b0, 1'b1);
    total++; if (s_out_valid !== 1'b1) begin bad++; $display("[TB] FAIL basic_valid got=%b exp=1", s_out_valid); end
    total++; if (s_out_data !== 48'd9) begin bad++; $display("[TB] FAIL basic_data got=%h exp=9", s_out_data); end
    total++; if (s_out_cnt !== 16'd3 || s_out_ovf !== 1'b0) begin bad++; $display("[TB] FAIL basic_cnt_ovf got=%0d/%b exp=3/0", s_out_cnt, s_out_ovf); end
    total++; if (w_out_cnt !== 2'd3) begin bad++; $display("[TB] FAIL basic_wrap_cnt got=%0d exp=3", w_out_cnt); end
    idle();
    total++; if (s_out_valid !== 1'b0) begin bad++; $display("[TB] FAIL basic_drop got=%b exp=0", s_out_valid); end
  endtask

  task automatic test_overflow();
    // 0x7FFF_FFFF_FFF0 + 0x20 crosses the positive limit; wrapped sum is 0x8000_0000_0010.
    send(48'h7FFF_FFFF_FFF0, 1'b0, 1'b0, 1'b0);
    send(48'h0000_0000_0020, 1'b0, 1'b0, 1'b1);
    total++; if (s_out_data !== 48'h7FFF_FFFF_FFFF) begin bad++; $display("[TB] FAIL ovf_sat_data got=%h exp=7fffffffffff", s_out_data); end
    total++; if (s_out_ovf !== 1'b1) begin bad++; $display("[TB] FAIL ovf_sat_flag got=%b exp=1", s_out_ovf); end
    total++; if (w_out_data !== 48'h8000_0000_0010) begin bad++; $display("[TB] FAIL ovf_wrap_data got=%h exp=800000000010", w_out_data); end
    total++; if (w_out_ovf !== 1'b1) begin bad++; $display("[TB] FAIL ovf_wrap_flag got=%b exp=1", w_out_ovf); end
    idle();
  endtask

  task automatic test_sub_min();
    send(48'h8000_0000_0000, 1'b1, 1'b1, 1'b1);
    total++; if (s_out_data !== 48'h7FFF_FFFF_FFFF || s_out_ovf !== 1'b1) begin bad++; $display("[TB] FAIL submin_sat got=%h/%b exp=7fffffffffff/1", s_out_data, s_out_ovf); end
    total++; if (w_out_data !== 48'h8000_0000_0000 || w_out_ovf !== 1'b1) begin bad++; $display("[TB] FAIL submin_wrap got=%h/%b exp=800000000000/1", w_out_data, w_out_ovf); end
    send(48'd1, 1'b0, 1'b0, 1'b1);
    total++; if (s_out_data !== 48'd1 || s_out_ovf !== 1'b0 || s_out_cnt !== 16'd1) begin bad++; $display("[TB] FAIL submin_next got=%h/%b/%0d exp=1/0/1", s_out_data, s_out_ovf, s_out_cnt); end
    idle();
  endtask

  task automatic test_subtract();
    send(48'd100, 1'b0, 1'b0, 1'b0);
    send(48'd130, 1'b1, 1'b0, 1'b1);
    total++; if (s_out_data !== 48'hFFFF_FFFF_FFE2 || s_out_ovf !== 1'b0) begin bad++; $display("[TB] FAIL sub_data got=%h/%b exp=ffffffffffe2/0", s_out_data, s_out_ovf); end
    idle();
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    send(48'd11, 1'b0, 1'b1, 1'b1);
    total++; if (s_out_valid !== 1'b1 || s_out_data !== 48'd11) begin bad++; $display("[TB] FAIL stall_first got=%b/%h exp=1/b", s_out_valid, s_out_data); end
    in_data = 48'd99;
    in_clr  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      total++; if (s_in_ready !== 1'b0) begin bad++; $display("[TB] FAIL stall_ready[%0d] got=%b exp=0", i, s_in_ready); end
      total++; if (s_out_valid !== 1'b1 || s_out_data !== 48'd11 || s_out_cnt !== 16'd1) begin bad++; $display("[TB] FAIL stall_hold[%0d] got=%b/%h/%0d exp=1/b/1", i, s_out_valid, s_out_data, s_out_cnt); end
    end
    out_ready = 1'b1;
    #1;
    total++; if (s_in_ready !== 1'b1) begin bad++; $display("[TB] FAIL stall_release got=%b exp=1", s_in_ready); end
    @(posedge clk);
    #1;
    total++; if (s_out_valid !== 1'b1 || s_out_data !== 48'd99) begin bad++; $display("[TB] FAIL stall_next got=%b/%h exp=1/63", s_out_valid, s_out_data); end
    idle();
    total++; if (s_out_valid !== 1'b0) begin bad++; $display("[TB] FAIL stall_drop got=%b exp=0", s_out_valid); end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 4; i++) begin
      send(48'(i * 3), 1'b0, 1'b0, 1'b1);
      total++; if (s_out_valid !== 1'b1 || s_out_data !== 48'(i * 3) || s_out_cnt !== 16'd1) begin bad++; $display("[TB] FAIL b2b[%0d] got=%b/%h/%0d exp=1/%h/1", i, s_out_valid, s_out_data, s_out_cnt, 48'(i * 3)); end
    end
    idle();
    total++; if (s_out_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_drop got=%b exp=0", s_out_valid); end
  endtask

  task automatic test_clr();
    send(48'd10, 1'b0, 1'b0, 1'b0);
    send(48'd20, 1'b0, 1'b0, 1'b0);
    send(48'd30, 1'b0, 1'b1, 1'b0);
    send(48'd40, 1'b0, 1'b0, 1'b1);
    total++; if (s_out_data !== 48'd70 || s_out_cnt !== 16'd2) begin bad++; $display("[TB] FAIL clr_mid got=%h/%0d exp=46/2", s_out_data, s_out_cnt); end
    idle();
  endtask

  task automatic test_cnt_sat();
    for (int i = 0; i < 5; i++) send(48'd1, 1'b0, 1'b0, (i == 4));
    total++; if (s_out_data !== 48'd5 || s_out_cnt !== 16'd5) begin bad++; $display("[TB] FAIL cnt_wide got=%h/%0d exp=5/5", s_out_data, s_out_cnt); end
    total++; if (w_out_cnt !== 2'd3) begin bad++; $display("[TB] FAIL cnt_sat got=%0d exp=3", w_out_cnt); end
    idle();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    send(48'd8, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    total++; if (s_out_valid !== 1'b0 || s_out_data !== 48'd0 || s_out_cnt !== 16'd0) begin bad++; $display("[TB] FAIL arst_out got=%b/%h/%0d exp=0/0/0", s_out_valid, s_out_data, s_out_cnt); end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    send(48'd100, 1'b0, 1'b0, 1'b0);
    send(48'd200, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    total++; if (s_out_valid !== 1'b0 || s_out_ovf !== 1'b0) begin bad++; $display("[TB] FAIL arst_mid got=%b/%b exp=0/0", s_out_valid, s_out_ovf); end
    @(negedge clk);
    rst = 1'b0;
    send(48'd4, 1'b0, 1'b0, 1'b1);
    total++; if (s_out_data !== 48'd4 || s_out_cnt !== 16'd1 || s_out_valid !== 1'b1) begin bad++; $display("[TB] FAIL arst_after got=%h/%0d/%b exp=4/1/1", s_out_data, s_out_cnt, s_out_valid); end
    idle();
  endtask

  initial begin
    in_valid  = 1'b0;
    in_data   = '0;
    in_sub    = 1'b0;
    in_clr    = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_basic();
    test_overflow();
    test_sub_min();
    test_subtract();
    test_stall();
    test_back_to_back();
    test_clr();
    test_cnt_sat();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
